// File: rtl/pps_pulse_gen.sv
// Regenerates a clean, programmable-width output pulse from a single-cycle trigger.
// Define PPS_FLYWHEEL_EN to add the accept window, synthetic pulses and early/missed/holdover flags.
module pps_pulse_gen #(
  parameter int PERIOD  = 10_000_000,
  parameter int TOL     = 100,
  parameter int WIDTH_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               trig,
  input  logic [WIDTH_W-1:0] width,
  output logic               out,
  output logic               busy,
  output logic               early,
  output logic               missed,
  output logic               holdover
);

  localparam int CNT_MAX = PERIOD + TOL;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_MAX);

  // Bit 0 of the state is the output pulse itself, so out comes straight off a flop.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_HIGH = 2'b01;
  localparam logic [1:0] ST_LOW  = 2'b10;

  logic [1:0]         state_q, state_d;
  logic [WIDTH_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               start;

`ifdef PPS_FLYWHEEL_EN
  localparam logic [CNT_W-1:0] ACC_MIN = CNT_W'(PERIOD - TOL);
  logic early_q, early_d;
  logic missed_q, missed_d;
  logic hold_q, hold_d;
`endif

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    start   = 1'b0;
    cnt_d   = (state_q == ST_IDLE || cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
`ifdef PPS_FLYWHEEL_EN
    early_d  = 1'b0;
    missed_d = 1'b0;
    hold_d   = hold_q;
`endif
    case (state_q)
      ST_IDLE: start = trig;
      ST_HIGH: begin
        if (rem_q == '0) state_d = ST_LOW;
        else             rem_d   = rem_q - WIDTH_W'(1);
`ifdef PPS_FLYWHEEL_EN
        early_d = trig;
`endif
      end
      ST_LOW: begin
`ifdef PPS_FLYWHEEL_EN
        // A real trigger always beats the synthetic event on the same cycle.
        if (trig) begin
          if (cnt_q >= ACC_MIN) begin
            start  = 1'b1;
            hold_d = 1'b0;
          end else begin
            early_d = 1'b1;
          end
        end else if (cnt_q == CNT_SAT) begin
          start    = 1'b1;
          missed_d = 1'b1;
          hold_d   = 1'b1;
        end
`else
        start = trig;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    if (start) begin
      state_d = ST_HIGH;
      cnt_d   = '0;
      rem_d   = (width == '0) ? '0 : width - WIDTH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out  = state_q[0];
  assign busy = state_q[0];

`ifdef PPS_FLYWHEEL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      early_q  <= 1'b0;
      missed_q <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      early_q  <= early_d;
      missed_q <= missed_d;
      hold_q   <= hold_d;
    end
  end

  assign early    = early_q;
  assign missed   = missed_q;
  assign holdover = hold_q;
`else
  assign early    = 1'b0;
  assign missed   = 1'b0;
  assign holdover = 1'b0;
`endif

endmodule
